serial_in_parallel_out: RTL
===========================

Name: serial_in_parallel_out

Overview:
- Downstream stage of the 4-bit parallel-in/serial-out shifter: captures its serial output bit stream and reassembles WIDTH-bit parallel words.
- Bits are sampled while `shift_en` is high, MSB first: the first bit shifted out is `da`, which becomes `dout[WIDTH-1]`.
- Completed words are offered on a valid/ready interface through a one-entry holding register.
- A sticky overrun flag reports words lost because the consumer stalled.

Parameters:
- WIDTH, 4, bits per assembled word; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- serial_in  input  1  serial data from the upstream shifter output.
- shift_en  input  1  bit-valid qualifier; serial_in sampled on each rising clk edge where high.
- frame_sync  input  1  word realignment; clears partial word and bit counter.
- dout  output  WIDTH  assembled word from the holding register.
- dout_valid  output  1  holding register contains an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
- bit_cnt  output  clog2(WIDTH)+1  bits collected in the current partial word.
- overrun  output  1  sticky: a completed word was dropped.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst_n low, asynchronous): shift register=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0.
  - Reset mid-word discards the partial word and any held word.
  - Reset release is synchronous to clk.
- Assembly FSM states:
  - IDLE: bit_cnt=0.
  - COLLECT: 0<bit_cnt<WIDTH.
  - IDLE->COLLECT on the first sampled bit.
  - COLLECT->IDLE on word completion or frame_sync.
- Shift:
  - When shift_en=1: `sreg <= {sreg[WIDTH-2:0], serial_in}`, bit_cnt increments.
  - When shift_en=0: sreg and bit_cnt hold; a paused word resumes later with no loss.
- Completion:
  - A word completes on the edge where shift_en=1 and bit_cnt==WIDTH-1.
  - The completed word is `{sreg[WIDTH-2:0], serial_in}`.
  - bit_cnt returns to 0 on the same edge.
  - The word loads into dout on that edge; dout_valid rises the cycle after the final bit is sampled (latency 1 clk).
- Holding register:
  - Consume: dout_valid && dout_ready clears dout_valid on the next edge unless a new word loads on that same edge.
  - Simultaneous consume and completion: new word loads, dout_valid stays 1, no overrun.
  - Completion while dout_valid=1 and dout_ready=0: new word dropped, dout unchanged, overrun set to 1.
  - dout is stable while dout_valid=1 and not consumed.
- frame_sync:
  - Synchronous; clears sreg and bit_cnt, and takes priority over shift_en on the same edge.
  - Does not affect dout, dout_valid or overrun.
- overrun:
  - Cleared by overrun_clr.
  - If overrun_clr and a new overrun occur on the same edge, the set wins.
- Continuous shifting (shift_en held high) produces back-to-back words every WIDTH cycles with no gap bit.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- When defined:
  - Each frame is WIDTH data bits followed by one even-parity bit; completion occurs on bit WIDTH.
  - The parity bit is not placed in dout.
  - Extra output `parity_err` (1 bit) is registered alongside dout on word load: 1 if XOR of data bits and parity bit is 1.
  - parity_err resets to 0 and is valid while dout_valid=1.
  - bit_cnt range extends to WIDTH.
- When undefined:
  - No parity bit and no parity_err port.
  - Frames are exactly WIDTH bits.

Test Plan:
- Reset, then shift 1,0,0,1 with shift_en=1 and dout_ready=1 (WIDTH=4) -> dout=4'b1001 and dout_valid=1 exactly one cycle after the 4th bit; dout_valid=0 the following cycle.
- Shift 1,1 then shift_en=0 for 5 cycles, then 0,1 -> bit_cnt holds at 2 during the pause; dout=4'b1101.
- dout_ready=0, send 4'b1010 then 4'b0110 -> dout stays 4'b1010, overrun=1; pulse overrun_clr -> overrun=0.
- Continuous shift of 4'b0011 then 4'b1100 with dout_ready asserted on the completion edge of word 2 -> dout=4'b1100, dout_valid stays 1, overrun=0.
- Shift 1,0,1, pulse frame_sync, then shift 0,1,1,1 -> bit_cnt=0 after sync, dout=4'b0111. Also assert rst_n low mid-word -> all outputs 0 immediately, no word emitted.
- With SIPO_PARITY_EN: send 1,0,0,1 + parity 0 -> dout=4'b1001, parity_err=0; send 1,0,0,0 + parity 0 -> parity_err=1.

Source files
------------

// File: rtl/serial_in_parallel_out_if.sv
// Word output channel of the serial-to-parallel assembler: dout with valid/ready.
// Carries parity_err as well when SIPO_PARITY_EN is defined.
interface serial_in_parallel_out_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
`ifdef SIPO_PARITY_EN
    logic             parity_err;
`endif

    modport master (
`ifdef SIPO_PARITY_EN
        output parity_err,
`endif
        output dout, dout_valid,
        input  dout_ready
    );

    modport slave (
`ifdef SIPO_PARITY_EN
        input  parity_err,
`endif
        input  dout, dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/serial_in_parallel_out.sv
// Reassembles an MSB-first serial bit stream into WIDTH-bit words behind a one-entry holding register.
// Optional SIPO_PARITY_EN: each frame carries a trailing even-parity bit checked into parity_err.
module serial_in_parallel_out #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     serial_in,
    input  logic                     shift_en,
    input  logic                     frame_sync,
    input  logic                     overrun_clr,
    output logic [$clog2(WIDTH):0]   bit_cnt,
    output logic                     overrun,
    serial_in_parallel_out_if.master out_if
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef SIPO_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             complete, load, drop;
`ifdef SIPO_PARITY_EN
    logic             word_perr;
    logic             perr_q;
`endif

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        complete  = shift_en && !frame_sync && (bit_cnt == LAST_BIT);
        load      = complete && (!valid_q || out_if.dout_ready);
        drop      = complete && valid_q && !out_if.dout_ready;
`ifdef SIPO_PARITY_EN
        // serial_in is the parity bit on the completing edge; sreg already holds all data bits.
        word      = sreg;
        word_perr = (^sreg) ^ serial_in;
`else
        word      = {sreg[WIDTH-2:0], serial_in};
`endif
        unique case (state)
            IDLE:    if (shift_en && !frame_sync) state_nxt = COLLECT;
            COLLECT: if (frame_sync || complete)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (frame_sync) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            sreg    <= {sreg[WIDTH-2:0], serial_in};
            bit_cnt <= complete ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // Holding register: a load overrides a same-edge consume, so valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            dout_q  <= word;
            valid_q <= 1'b1;
        end else if (valid_q && out_if.dout_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    perr_q <= 1'b0;
        else if (load) perr_q <= word_perr;
    end
    assign out_if.parity_err = perr_q;
`endif

    // A dropped word wins over a same-edge clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (overrun_clr) overrun <= 1'b0;
    end

    assign out_if.dout       = dout_q;
    assign out_if.dout_valid = valid_q;
endmodule
